// File: rtl/ram_port_arbiter_pkg.sv
// ram_port_arbiter_pkg: shared widths, FSM/grant encodings and the bank-boundary pre-fault test
package ram_port_arbiter_pkg;
  localparam int ADDR_W     = 11;
  localparam int DATA_W     = 32;
  localparam int NBANK      = 8;
  localparam int LAST_SAFE  = 252;
  localparam int BANK_OFS_W = 8;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;
  typedef enum logic {GNT_IF = 1'b0, GNT_D = 1'b1} gnt_e;
  function automatic logic pre_fault(input logic [ADDR_W-1:0] a);
    return a[BANK_OFS_W-1:0] > BANK_OFS_W'(LAST_SAFE);
  endfunction
endpackage

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: fetch and data requester handshakes toward the RAM port arbiter
interface ram_port_arbiter_if;
  import ram_port_arbiter_pkg::*;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;
  logic              if_err;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata,
    input  if_ack, if_rdata, if_err, d_ack, d_rdata, d_err
  );
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata,
    output if_ack, if_rdata, if_err, d_ack, d_rdata, d_err
  );
endinterface

// File: rtl/ram_port_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin picker; req[0]=fetch, req[1]=data, one-hot gnt
module rr_arb2
  import ram_port_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  gnt_e last_gnt_q, last_gnt_d;
  // on a conflict favour whoever was not served last; remember a grant only when it is taken
  always_comb begin
    gnt        = (req == 2'b11) ? ((last_gnt_q == GNT_D) ? 2'b01 : 2'b10) : req;
    last_gnt_d = (en && |req) ? (gnt[1] ? GNT_D : GNT_IF) : last_gnt_q;
  end
  // reset to data-last so fetch wins the first conflict
  always_ff @(posedge clk)
    last_gnt_q <= rst ? GNT_D : last_gnt_d;
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: serialises fetch reads and data loads/stores onto the shared banked RAM port
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  ram_port_arbiter_if.slave     bus,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_din,
  output logic                  ram_we,
  input  logic [DATA_W-1:0]     ram_dout,
  input  logic [NBANK-1:0]      ram_seg_faults
);
  state_e            state_q, state_d;
  gnt_e              gnt_id_q, gnt_id_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d, pf_q, pf_d;
  logic              idle, busy, issue, g_d, iss_pf, err;
  logic [1:0]        gnt;
  logic [ADDR_W-1:0] iss_addr;
  logic [DATA_W-1:0] rd;
  assign idle  = !rst && state_q == IDLE;
  assign busy  = !rst && state_q == BUSY;
  assign issue = idle && |gnt;
  assign g_d   = gnt[1];
  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .en  (idle),
    .req ({bus.d_req, bus.if_req}),
    .gnt (gnt)
  );
  // drive the RAM port and the requester responses; everything is forced to 0 while rst is high
  always_comb begin
    iss_addr     = g_d ? bus.d_addr : bus.if_addr;
    iss_pf       = pre_fault(iss_addr);
    ram_addr     = busy ? addr_q : issue ? iss_addr : '0;
    ram_din      = (idle && g_d) ? bus.d_wdata : '0;
    ram_we       = idle && g_d && bus.d_we && !iss_pf;
    rd           = (we_q || pf_q) ? '0 : ram_dout;
    err          = pf_q || (we_q && ram_seg_faults[addr_q[ADDR_W-1:BANK_OFS_W]]);
    bus.if_ack   = busy && gnt_id_q == GNT_IF;
    bus.d_ack    = busy && gnt_id_q == GNT_D;
    bus.if_rdata = bus.if_ack ? rd : '0;
    bus.d_rdata  = bus.d_ack ? rd : '0;
    bus.if_err   = bus.if_ack && err;
    bus.d_err    = bus.d_ack && err;
  end
  // latch the granted access on issue; BUSY always falls back to IDLE
  always_comb begin
    state_d  = issue ? BUSY : IDLE;
    gnt_id_d = issue ? (g_d ? GNT_D : GNT_IF) : gnt_id_q;
    addr_d   = issue ? iss_addr : addr_q;
    we_d     = issue ? (g_d && bus.d_we) : we_q;
    pf_d     = issue ? iss_pf : pf_q;
  end
  // FSM and transaction registers; reset aborts any access in flight without an ack
  always_ff @(posedge clk)
    if (rst) begin
      state_q  <= IDLE;
      gnt_id_q <= GNT_IF;
      addr_q   <= '0;
      we_q     <= 1'b0;
      pf_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_id_q <= gnt_id_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      pf_q     <= pf_d;
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: scenario and randomized checks of the RAM port arbiter against a byte-array model
module tb_ram_port_arbiter;
  import ram_port_arbiter_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  ram_port_arbiter_if bus();
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din, ram_dout;
  logic              ram_we;
  logic [NBANK-1:0]  seg;
  ram_port_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .ram_addr       (ram_addr),
    .ram_din        (ram_din),
    .ram_we         (ram_we),
    .ram_dout       (ram_dout),
    .ram_seg_faults (seg)
  );
  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  logic [7:0] ram_mem [0:2047];
  logic [7:0] ref_mem [0:2047];

  function automatic logic [10:0] bidx(input logic [10:0] a, input int i);
    return {a[10:8], 8'(int'(a[7:0]) + i)};
  endfunction

  // RAM: one-cycle registered read; a word write wraps inside its bank, which is the corruption the arbiter must prevent
  always @(posedge clk) begin
    if (ram_we) we_cnt <= we_cnt + 1;
    ram_dout <= {ram_mem[bidx(ram_addr, 3)], ram_mem[bidx(ram_addr, 2)],
                 ram_mem[bidx(ram_addr, 1)], ram_mem[bidx(ram_addr, 0)]};
    if (ram_we) for (int i = 0; i < 4; i++) ram_mem[bidx(ram_addr, i)] = ram_din[8*i +: 8];
  end

  function automatic logic is_pf(input logic [10:0] a);
    return int'(a % 256) > 252;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [10:0] a);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = ref_mem[int'(a) + i];
    return w;
  endfunction

  task automatic ref_wr(input logic [10:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) ref_mem[int'(a) + i] = w[8*i +: 8];
  endtask

  function automatic logic [10:0] rand_addr();
    logic [10:0] a;
    a = 11'($urandom);
    if ($urandom_range(0, 3) == 0) a[7:0] = 8'(248 + $urandom_range(0, 7));
    return a;
  endfunction

  // presents one request from idle and waits (bounded) for its ack; lat=99 means no ack came
  task automatic txn(input bit is_d, input logic we, input logic [10:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er, output int lat);
    bit got = 0;
    if (is_d) begin
      bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = a; bus.d_wdata = wd;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = a;
    end
    rd = '0; er = 1'b0; lat = 99;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      if (is_d ? bus.d_ack : bus.if_ack) begin
        got = 1; lat = c;
        rd = is_d ? bus.d_rdata : bus.if_rdata;
        er = is_d ? bus.d_err : bus.if_err;
      end
    end
    @(posedge clk); #1;
    if (is_d) bus.d_req = 1'b0; else bus.if_req = 1'b0;
  endtask

  task automatic test_reset;
    bus.if_req = 1'b1; bus.if_addr = 11'h100;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 11'h104; bus.d_wdata = 32'h12345678;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_ram_we: got %b expected 0", ram_we); end
    checks++; if (ram_addr !== '0 || ram_din !== '0) begin errors++; $display("FAIL rst_ram_bus: got addr %h din %h expected 0", ram_addr, ram_din); end
    checks++; if ({bus.if_ack, bus.d_ack, bus.if_err, bus.d_err} !== 4'b0 || bus.if_rdata !== '0 || bus.d_rdata !== '0) begin
      errors++; $display("FAIL rst_resp: got acks %b%b errs %b%b expected all 0", bus.if_ack, bus.d_ack, bus.if_err, bus.d_err);
    end
    @(posedge clk); #1;
    bus.if_req = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0; rst = 1'b0;
    @(negedge clk);
    checks++; if (ram_addr !== '0 || ram_we !== 1'b0 || ram_din !== '0) begin errors++; $display("FAIL idle_ram_bus: got addr %h we %b din %h expected 0", ram_addr, ram_we, ram_din); end
    checks++; if (we_cnt !== 0) begin errors++; $display("FAIL rst_write_suppressed: got %0d writes expected 0", we_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_store_load;
    logic [31:0] rd; logic er; int lat; int w0 = we_cnt;
    txn(1, 1, 11'h104, 32'hDEADBEEF, rd, er, lat);
    ref_wr(11'h104, 32'hDEADBEEF);
    checks++; if (lat !== 2) begin errors++; $display("FAIL store_latency: got %0d expected 2", lat); end
    checks++; if (er !== 1'b0 || rd !== '0) begin errors++; $display("FAIL store_resp: got err %b rdata %h expected 0 0", er, rd); end
    checks++; if (we_cnt - w0 !== 1) begin errors++; $display("FAIL store_we_cycles: got %0d expected 1", we_cnt - w0); end
    txn(1, 0, 11'h104, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat !== 2) begin errors++; $display("FAIL load_back: got %h err %b lat %0d expected deadbeef 0 2", rd, er, lat); end
  endtask

  task automatic test_conflict;
    logic ei, ed;
    rst = 1'b1;
    @(posedge clk); #1;
    bus.if_req = 1'b1; bus.if_addr = 11'h208;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 11'h444;
    rst = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      ei = (c % 4 == 2); ed = (c % 4 == 0);
      checks++; if (bus.if_ack !== ei || bus.d_ack !== ed) begin errors++; $display("FAIL conflict_order c%0d: got if %b d %b expected if %b d %b", c, bus.if_ack, bus.d_ack, ei, ed); end
      if (ei) begin checks++; if (bus.if_rdata !== ref_rd(11'h208)) begin errors++; $display("FAIL conflict_if_data: got %h expected %h", bus.if_rdata, ref_rd(11'h208)); end end
      if (ed) begin checks++; if (bus.d_rdata !== ref_rd(11'h444)) begin errors++; $display("FAIL conflict_d_data: got %h expected %h", bus.d_rdata, ref_rd(11'h444)); end end
    end
    @(posedge clk); #1;
    bus.if_req = 1'b0; bus.d_req = 1'b0;
  endtask

  task automatic test_prefault;
    logic [31:0] rd; logic er; int lat; int w0 = we_cnt; logic [31:0] w = $urandom;
    txn(1, 1, 11'h0FE, w, rd, er, lat);
    checks++; if (er !== 1'b1 || rd !== '0 || lat !== 2) begin errors++; $display("FAIL pf_store: got err %b rdata %h lat %0d expected 1 0 2", er, rd, lat); end
    checks++; if (we_cnt !== w0) begin errors++; $display("FAIL pf_store_no_write: got %0d writes expected 0", we_cnt - w0); end
    txn(1, 0, 11'h0FC, 32'h0, rd, er, lat);
    checks++; if (rd !== ref_rd(11'h0FC) || er !== 1'b0) begin errors++; $display("FAIL pf_readback: got %h err %b expected %h 0", rd, er, ref_rd(11'h0FC)); end
    txn(1, 0, 11'h1FD, 32'h0, rd, er, lat);
    checks++; if (er !== 1'b1 || rd !== '0) begin errors++; $display("FAIL pf_load: got err %b rdata %h expected 1 0", er, rd); end
    w = $urandom;
    txn(1, 1, 11'h2FC, w, rd, er, lat);
    ref_wr(11'h2FC, w);
    checks++; if (er !== 1'b0 || we_cnt - w0 !== 1) begin errors++; $display("FAIL edge_store: got err %b writes %0d expected 0 1", er, we_cnt - w0); end
    txn(1, 0, 11'h2FC, 32'h0, rd, er, lat);
    checks++; if (rd !== w || er !== 1'b0) begin errors++; $display("FAIL edge_load: got %h err %b expected %h 0", rd, er, w); end
  endtask

  task automatic test_prefault_fetch;
    logic [31:0] rd; logic er; int lat; int w0 = we_cnt;
    txn(0, 0, 11'h7FD, 32'h0, rd, er, lat);
    checks++; if (er !== 1'b1 || rd !== '0 || lat !== 2) begin errors++; $display("FAIL pf_fetch: got err %b rdata %h lat %0d expected 1 0 2", er, rd, lat); end
    checks++; if (we_cnt !== w0) begin errors++; $display("FAIL pf_fetch_no_write: got %0d writes expected 0", we_cnt - w0); end
    txn(0, 0, 11'h7FC, 32'h0, rd, er, lat);
    checks++; if (rd !== ref_rd(11'h7FC) || er !== 1'b0) begin errors++; $display("FAIL edge_fetch: got %h err %b expected %h 0", rd, er, ref_rd(11'h7FC)); end
  endtask

  task automatic test_reset_busy;
    int ack_c = 0;
    logic [31:0] rd = '0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 11'h520;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.d_ack !== 1'b0 || bus.if_ack !== 1'b0) begin errors++; $display("FAIL rst_busy_ack: got d %b if %b expected 0 0", bus.d_ack, bus.if_ack); end
    checks++; if (ram_we !== 1'b0 || ram_addr !== '0 || bus.d_rdata !== '0 || bus.d_err !== 1'b0) begin
      errors++; $display("FAIL rst_busy_outs: got we %b addr %h rdata %h err %b expected 0", ram_we, ram_addr, bus.d_rdata, bus.d_err);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 1; c <= 10 && ack_c == 0; c++) begin
      @(negedge clk);
      if (c == 1) begin checks++; if (ram_addr !== 11'h520 || bus.d_ack !== 1'b0) begin errors++; $display("FAIL rst_busy_idle: got addr %h ack %b expected 520 0", ram_addr, bus.d_ack); end end
      if (bus.d_ack) begin ack_c = c; rd = bus.d_rdata; end
    end
    checks++; if (ack_c !== 2 || rd !== ref_rd(11'h520)) begin errors++; $display("FAIL rst_busy_retry: got cycle %0d data %h expected 2 %h", ack_c, rd, ref_rd(11'h520)); end
    @(posedge clk); #1;
    bus.d_req = 1'b0;
  endtask

  task automatic test_seg_fault;
    logic [31:0] rd; logic er; int lat; logic [31:0] w3 = $urandom; logic [31:0] w5 = $urandom;
    seg = 8'h08;
    txn(1, 1, 11'h310, w3, rd, er, lat);
    ref_wr(11'h310, w3);
    checks++; if (er !== 1'b1 || rd !== '0) begin errors++; $display("FAIL seg_bank3: got err %b rdata %h expected 1 0", er, rd); end
    txn(1, 1, 11'h530, w5, rd, er, lat);
    ref_wr(11'h530, w5);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL seg_bank5: got err %b expected 0", er); end
    txn(1, 0, 11'h310, 32'h0, rd, er, lat);
    checks++; if (er !== 1'b0 || rd !== w3) begin errors++; $display("FAIL seg_load: got err %b rdata %h expected 0 %h", er, rd, w3); end
    seg = '0;
  endtask

  task automatic test_random;
    logic pend [2];
    logic [10:0] ad [2];
    int age [2];
    int exp_we = 0;
    int w0 = we_cnt;
    logic got, st, pfl, exp_er, got_er;
    logic [31:0] exp_rd, got_rd;
    pend = '{1'b0, 1'b0};
    age = '{0, 0};
    for (int cyc = 0; cyc < 460; cyc++) begin
      if (cyc < 400) begin
        if (!pend[0] && $urandom_range(0, 2) != 0) begin
          ad[0] = rand_addr(); pend[0] = 1'b1; age[0] = 0;
          bus.if_req = 1'b1; bus.if_addr = ad[0];
        end
        if (!pend[1] && $urandom_range(0, 2) != 0) begin
          ad[1] = rand_addr(); pend[1] = 1'b1; age[1] = 0;
          bus.d_req = 1'b1; bus.d_addr = ad[1]; bus.d_we = 1'($urandom_range(0, 1)); bus.d_wdata = $urandom;
        end
      end
      seg = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      @(negedge clk);
      checks++; if (bus.if_ack && bus.d_ack) begin errors++; $display("FAIL rand_dual_ack: got both acks expected at most one"); end
      checks++; if (!bus.if_ack && (bus.if_rdata !== '0 || bus.if_err !== 1'b0)) begin errors++; $display("FAIL rand_if_idle_out: got %h %b expected 0 0", bus.if_rdata, bus.if_err); end
      checks++; if (!bus.d_ack && (bus.d_rdata !== '0 || bus.d_err !== 1'b0)) begin errors++; $display("FAIL rand_d_idle_out: got %h %b expected 0 0", bus.d_rdata, bus.d_err); end
      for (int r = 0; r < 2; r++) begin
        if (pend[r]) begin
          age[r]++;
          got = (r == 1) ? bus.d_ack : bus.if_ack;
          if (got) begin
            st = (r == 1) && bus.d_we;
            pfl = is_pf(ad[r]);
            exp_er = pfl || (st && seg[ad[r][10:8]]);
            exp_rd = (st || pfl) ? 32'h0 : ref_rd(ad[r]);
            got_rd = (r == 1) ? bus.d_rdata : bus.if_rdata;
            got_er = (r == 1) ? bus.d_err : bus.if_err;
            checks++; if (got_rd !== exp_rd) begin errors++; $display("FAIL rand_rdata r%0d @%h: got %h expected %h", r, ad[r], got_rd, exp_rd); end
            checks++; if (got_er !== exp_er) begin errors++; $display("FAIL rand_err r%0d @%h: got %b expected %b", r, ad[r], got_er, exp_er); end
            checks++; if (age[r] > 4) begin errors++; $display("FAIL rand_latency r%0d: got %0d expected <= 4", r, age[r]); end
            if (st && !pfl) begin ref_wr(ad[r], bus.d_wdata); exp_we++; end
            pend[r] = 1'b0;
          end else if (age[r] == 4) begin
            checks++; errors++; $display("FAIL rand_starve r%0d: got no ack after 4 cycles expected ack", r);
          end
        end
      end
      @(posedge clk); #1;
      if (!pend[0]) bus.if_req = 1'b0;
      if (!pend[1]) bus.d_req = 1'b0;
    end
    checks++; if (pend[0] || pend[1]) begin errors++; $display("FAIL rand_drain: got pending %b%b expected 00", pend[0], pend[1]); end
    checks++; if (we_cnt - w0 !== exp_we) begin errors++; $display("FAIL rand_write_count: got %0d expected %0d", we_cnt - w0, exp_we); end
    bus.if_req = 1'b0; bus.d_req = 1'b0; seg = '0;
  endtask

  initial begin
    logic [7:0] b;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    seg = '0;
    for (int i = 0; i < 2048; i++) begin
      b = 8'($urandom);
      ram_mem[i] = b;
      ref_mem[i] = b;
    end
    test_reset;
    test_store_load;
    test_conflict;
    test_prefault;
    test_prefault_fetch;
    test_reset_busy;
    test_seg_fault;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 expected earlier finish");
    $fatal(1, "watchdog expired");
  end
endmodule
